// File: rtl/spi_master.sv
// SPI mode-0 (CPOL=0, CPHA=0) master shift engine, MSB first, one DATA_W-bit word per transfer.
//
// Ports:
//   clk, rst          system clock (rising edge) and asynchronous active-low reset
//   tx_data/tx_valid  word to send and start request; accepted when tx_valid & tx_ready
//   tx_ready          high only while idle
//   rx_data/rx_valid  received word, updated with a one-cycle rx_valid pulse
//   busy              high whenever a transfer is in progress (any state but idle)
//   sclk/mosi/miso    SPI clock (idles low), data out, data in
//   cs_n              active-low chip select, held low from accept through the hold phase
//
// Sequencing: IDLE -> SETUP (CLK_DIV cycles) -> SHIFT (2*DATA_W*CLK_DIV cycles)
//             -> DONE (CLK_DIV cycles) -> IDLE.
module spi_master #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n
);

  // A CLK_DIV of 1 still needs a one-bit counter that simply stays at 0.
  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = $clog2(DATA_W + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_W);

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StDone} state_e;

  state_e state_q, state_d;

  logic [DivW-1:0]   div_q, div_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic              rx_valid_q, rx_valid_d;

  logic div_end;
  logic last_fall;

  // div_q paces every timed phase: SETUP and DONE length, and the sclk half-period in SHIFT.
  assign div_end   = (div_q == DivLast);
  // bit_q counts rising edges, so the falling edge after the DATA_W-th rise ends SHIFT.
  assign last_fall = sclk_q && div_end && (bit_q == BitLast);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (tx_valid)  state_d = StSetup;
      StSetup: if (div_end)   state_d = StShift;
      StShift: if (last_fall) state_d = StDone;
      StDone:  if (div_end)   state_d = StIdle;
    endcase
  end

  // Datapath and registered pin next-state.
  always_comb begin
    div_d      = div_q;
    bit_d      = bit_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    rx_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tx_valid) begin
          // Latch the word and present its MSB now so it is stable for the whole setup time.
          tx_sr_d = tx_data;
          mosi_d  = tx_data[DATA_W-1];
          cs_n_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          rx_sr_d = '0;
        end
      end
      StSetup: begin
        div_d = div_end ? '0 : div_q + 1'b1;
      end
      StShift: begin
        if (div_end) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            // Rising sclk: the slave's bit is stable, capture it.
            rx_sr_d = {rx_sr_q[DATA_W-2:0], miso};
            bit_d   = bit_q + 1'b1;
          end else begin
            // Falling sclk: advance to the next outgoing bit.
            tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
            mosi_d  = tx_sr_q[DATA_W-2];
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StDone: begin
        if (div_end) begin
          div_d      = '0;
          cs_n_d     = 1'b1;
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q      <= '0;
      bit_q      <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      rx_valid_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      bit_q      <= bit_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // Outputs.
  always_comb begin
    tx_ready = (state_q == StIdle);
    busy     = (state_q != StIdle);
    rx_data  = rx_data_q;
    rx_valid = rx_valid_q;
    sclk     = sclk_q;
    mosi     = mosi_q;
    cs_n     = cs_n_q;
  end

endmodule
